uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Frame-level controller placed directly after the UART byte receiver (115.2 kBd, 50 MHz system clock). It takes the receiver's byte plus its one-cycle "ok" strobe and parses the frame HDR, LEN, LEN payload bytes, SUM. Valid payloads go into a 16-byte buffer, which is held for a downstream consumer under a valid/ack handshake. It also detects length errors, checksum errors, inter-byte timeouts and overruns.

Parameters:
Fclk, 50000000, system clock frequency in Hz
VEL, 115200, UART baud rate
HDR, 8'hA5, frame header byte
MAXLEN, 16, maximum payload length (buffer depth; 1..16)
TO_BYTES, 3, inter-byte timeout in character times; TO_CLK = TO_BYTES*10*(Fclk/VEL) = 13020 clocks at defaults

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
rx_data  in  8  received byte; valid only when rx_ok=1
rx_ok  in  1  one-cycle byte-received strobe
frame_ack  in  1  consumer releases buffer
rd_addr  in  4  payload read index
rd_data  out  8  buffer[rd_addr], registered (1-cycle latency)
frame_valid  out  1  complete good frame held in buffer
frame_len  out  5  payload length of held frame (1..MAXLEN)
busy  out  1  frame reception in progress (state LEN/DATA/SUM)
err_len  out  1  pulse: LEN==0 or LEN>MAXLEN
err_sum  out  1  pulse: checksum mismatch
err_timeout  out  1  pulse: inter-byte timeout mid-frame
overrun  out  1  pulse: byte received while buffer held

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high (rst), and has priority over all other activity.
- Values on reset: all outputs 0; state IDLE; byte counter, checksum and timeout counter cleared. Buffer contents are don't-care.
- Reset mid-frame: the partial frame is discarded and no error pulse is issued.
- Rules common to all states:
  - Bytes are consumed only on cycles with rx_ok=1.
  - Every error/overrun output is a single-cycle pulse, registered, asserted the cycle after the causing rx_ok or timeout.
- IDLE:
  - rx_ok with rx_data==HDR -> LEN.
  - Any other byte is ignored silently.
- LEN:
  - rx_ok with rx_data in 1..MAXLEN: store len, set sum=rx_data, idx=0 -> DATA.
  - Otherwise pulse err_len -> IDLE. An HDR value here counts as a length byte.
- DATA:
  - Each rx_ok writes buf[idx]=rx_data, sum=(sum+rx_data) mod 256, idx+1.
  - When idx reaches len-1 with a write -> SUM.
  - An HDR value here is ordinary data.
- SUM:
  - rx_ok with rx_data==sum: frame_len<=len, frame_valid<=1 -> HOLD.
  - Otherwise pulse err_sum -> IDLE.
- HOLD:
  - frame_valid stays 1 and the buffer is frozen.
  - frame_ack -> frame_valid<=0 next cycle -> IDLE.
  - rx_ok in HOLD (including the same cycle as frame_ack) drops the byte and pulses overrun.
  - frame_len is held until the next good frame completes.
- Timeout:
  - A 14-bit counter runs in LEN/DATA/SUM. It clears to 0 on every rx_ok and on entry to those states.
  - Reaching TO_CLK-1 without rx_ok: pulse err_timeout -> IDLE.
  - rx_ok on the same cycle the counter would expire: the byte is processed and there is no timeout.
  - The counter is held at 0 in IDLE/HOLD.
- Read port:
  - rd_data <= buf[rd_addr] every cycle, in every state.
  - rd_addr >= frame_len returns stale/don't-care data; the bench must not check it.
- frame_ack outside HOLD is ignored.
- Throughput: a byte per cycle is tolerated (no internal backpressure). The UART delivers a byte at most every ~4340 clocks.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69 -> frame_valid=1 one cycle after last rx_ok; frame_len=3; rd_addr 0,1,2 give rd_data 11,22,33 one cycle later. frame_ack -> frame_valid=0 next cycle.
- Checksum error: A5 03 11 22 33 6A -> err_sum single pulse, frame_valid stays 0. Then A5 01 7F 80 -> valid, len=1, rd_data[0]=7F.
- Length errors: A5 00 -> err_len. A5 11 (17) -> err_len. A5 10 + 16 bytes of 01 + 20 -> valid, len=16 (max boundary). Stray byte 55 in IDLE -> no pulses.
- Timeouts:
  - A5 02 AA, then silence for 13020 clocks -> err_timeout exactly once; busy falls. A following full frame is accepted.
  - Byte arriving at clock 13019 -> no timeout.
- Overrun: good frame held with no ack, then byte 42 -> overrun pulse; buffer and frame_len unchanged. rx_ok coincident with frame_ack -> overrun and valid cleared.
- Reset mid-frame: rst for 1 cycle during DATA -> all outputs 0, no error pulse. A subsequent good frame A5 02 01 02 05 -> valid, len=2.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART frame parser: HDR, LEN, payload, SUM into a held 16-byte buffer
module uart_rx_frame_ctrl #(
  parameter int         Fclk     = 50000000,
  parameter int         VEL      = 115200,
  parameter logic [7:0] HDR      = 8'hA5,
  parameter int         MAXLEN   = 16,
  parameter int         TO_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ok,
  input  logic       frame_ack,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_valid,
  output logic [4:0] frame_len,
  output logic       busy,
  output logic       err_len,
  output logic       err_sum,
  output logic       err_timeout,
  output logic       overrun
);

  // One character is 10 bit times; the timeout spans TO_BYTES characters.
  localparam int          TO_CLK  = TO_BYTES * 10 * (Fclk / VEL);
  localparam logic [13:0] TO_LAST = 14'(TO_CLK - 1);
  localparam logic [7:0]  MAX_B   = 8'(MAXLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_HOLD
  } state_t;

  state_t      state;
  logic [4:0]  len;
  logic [3:0]  idx;
  logic [7:0]  sum;
  logic [13:0] to_cnt;
  logic [7:0]  mem [0:15];

  // Payload storage: written only while collecting DATA, frozen otherwise.
  always_ff @(posedge clk) begin
    if (!rst && state == S_DATA && rx_ok) begin
      mem[idx] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= 5'd0;
      idx         <= 4'd0;
      sum         <= 8'd0;
      to_cnt      <= 14'd0;
      rd_data     <= 8'd0;
      frame_valid <= 1'b0;
      frame_len   <= 5'd0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
      err_sum     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rd_data     <= mem[rd_addr];
      err_len     <= 1'b0;
      err_sum     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;

      case (state)
        S_IDLE: begin
          to_cnt <= 14'd0;
          if (rx_ok && rx_data == HDR) begin
            state <= S_LEN;
            busy  <= 1'b1;
          end
        end

        S_LEN, S_DATA, S_SUM: begin
          if (!rx_ok) begin
            // A byte landing on the expiry cycle still wins over the timeout.
            if (to_cnt == TO_LAST) begin
              err_timeout <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
              to_cnt      <= 14'd0;
            end else begin
              to_cnt <= to_cnt + 14'd1;
            end
          end else begin
            to_cnt <= 14'd0;
            if (state == S_LEN) begin
              if (rx_data != 8'd0 && rx_data <= MAX_B) begin
                len   <= rx_data[4:0];
                sum   <= rx_data;
                idx   <= 4'd0;
                state <= S_DATA;
              end else begin
                err_len <= 1'b1;
                state   <= S_IDLE;
                busy    <= 1'b0;
              end
            end else if (state == S_DATA) begin
              sum <= sum + rx_data;
              idx <= idx + 4'd1;
              if ({1'b0, idx} == len - 5'd1) begin
                state <= S_SUM;
              end
            end else begin
              busy <= 1'b0;
              if (rx_data == sum) begin
                frame_len   <= len;
                frame_valid <= 1'b1;
                state       <= S_HOLD;
              end else begin
                err_sum <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end
        end

        S_HOLD: begin
          to_cnt <= 14'd0;
          if (rx_ok) begin
            overrun <= 1'b1;
          end
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed plus randomized frame checks for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int TO_CLK = 3 * 10 * (50000000 / 115200);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ok = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic       busy;
  logic       err_len;
  logic       err_sum;
  logic       err_timeout;
  logic       overrun;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ok(rx_ok),
    .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .frame_len(frame_len), .busy(busy),
    .err_len(err_len), .err_sum(err_sum), .err_timeout(err_timeout),
    .overrun(overrun)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_len = 0, n_sum = 0, n_to = 0, n_ovr = 0;
  int s_len = 0, s_sum = 0, s_to = 0, s_ovr = 0;
  logic [7:0] pl[$];

  // Count every cycle a pulse output is high; a stuck pulse shows up as a count above one.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_len)     n_len++;
      if (err_sum)     n_sum++;
      if (err_timeout) n_to++;
      if (overrun)     n_ovr++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ok   = 1'b1;
    @(negedge clk);
    rx_ok   = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_gap(input logic [7:0] b, input int maxgap);
    idle($urandom_range(0, maxgap));
    send(b);
  endtask

  task automatic chk_pulses(input string tag, input int el, input int es, input int et, input int eo);
    idle(2);
    chk({tag, ".err_len"},     n_len - s_len, el);
    chk({tag, ".err_sum"},     n_sum - s_sum, es);
    chk({tag, ".err_timeout"}, n_to - s_to,   et);
    chk({tag, ".overrun"},     n_ovr - s_ovr, eo);
    chk({tag, ".busy"},        busy, 0);
    s_len = n_len; s_sum = n_sum; s_to = n_to; s_ovr = n_ovr;
  endtask

  // Reference checksum: length byte plus all payload bytes, modulo 256.
  function automatic logic [7:0] calc_sum(input logic [7:0] lb);
    int s = lb;
    foreach (pl[i]) s += pl[i];
    return 8'(s);
  endfunction

  task automatic readback(input string tag);
    foreach (pl[i]) begin
      @(negedge clk);
      rd_addr = 4'(i);
      @(negedge clk);
      chk($sformatf("%s.rd_data[%0d]", tag, i), rd_data, pl[i]);
    end
  endtask

  task automatic ack(input string tag, input logic [4:0] len_exp);
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk({tag, ".valid_after_ack"}, frame_valid, 0);
    chk({tag, ".len_after_ack"}, frame_len, len_exp);
  endtask

  // Sends a whole frame; the outcome follows from the length and checksum rules alone.
  task automatic frame(input string tag, input logic [7:0] lb, input bit corrupt,
                       input int maxgap, input bit hold);
    logic [7:0] s;
    s = calc_sum(lb);
    if (corrupt) s = s + 8'($urandom_range(1, 255));
    send_gap(HDR, maxgap);
    send_gap(lb, maxgap);
    if (lb == 8'd0 || lb > 8'd16) begin
      chk({tag, ".valid"}, frame_valid, 0);
      chk_pulses(tag, 1, 0, 0, 0);
      return;
    end
    foreach (pl[i]) send_gap(pl[i], maxgap);
    send_gap(s, maxgap);
    if (corrupt) begin
      chk({tag, ".valid"}, frame_valid, 0);
      chk_pulses(tag, 0, 1, 0, 0);
    end else begin
      chk({tag, ".valid"}, frame_valid, 1);
      chk({tag, ".len"}, frame_len, lb);
      chk_pulses(tag, 0, 0, 0, 0);
      readback(tag);
      if (!hold) ack(tag, lb[4:0]);
    end
  endtask

  initial begin
    logic [7:0] lb;
    logic [7:0] s;

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.frame_valid", frame_valid, 0);
    chk("reset.frame_len", frame_len, 0);
    chk("reset.busy", busy, 0);
    chk("reset.rd_data", rd_data, 0);
    chk("reset.errors", {err_len, err_sum, err_timeout, overrun}, 0);

    pl = '{8'h11, 8'h22, 8'h33};
    chk("good.sum_byte", calc_sum(8'd3), 8'h69);
    frame("good3", 8'd3, 1'b0, 0, 1'b0);

    frame("sum_err", 8'd3, 1'b1, 0, 1'b0);

    pl = '{8'h7F};
    frame("len1", 8'd1, 1'b0, 0, 1'b0);

    frame("len0", 8'd0, 1'b0, 0, 1'b0);
    frame("len17", 8'd17, 1'b0, 0, 1'b0);

    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'h01);
    frame("len16", 8'd16, 1'b0, 1, 1'b0);

    send(8'h55);
    chk_pulses("stray", 0, 0, 0, 0);

    // Silence after the last byte: the pulse follows exactly TO_CLK clocks later.
    send(HDR);
    send(8'h02);
    send(8'hAA);
    chk("to.busy_mid", busy, 1);
    idle(TO_CLK - 1);
    chk("to.not_yet", err_timeout, 0);
    idle(1);
    chk("to.pulse", err_timeout, 1);
    idle(1);
    chk("to.single", err_timeout, 0);
    chk("to.valid", frame_valid, 0);
    chk_pulses("to", 0, 0, 1, 0);
    pl = '{8'h5A, 8'hC3};
    frame("after_to", 8'd2, 1'b0, 0, 1'b0);

    pl = '{8'h3C, 8'hC4};
    s = calc_sum(8'd2);
    send(HDR);
    idle(TO_CLK - 3);
    send(8'h02);
    send(8'h3C);
    idle(TO_CLK - 3);
    send(8'hC4);
    send(s);
    chk("late.valid", frame_valid, 1);
    chk("late.len", frame_len, 2);
    chk_pulses("late", 0, 0, 0, 0);
    readback("late");
    ack("late", 5'd2);

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    frame("ovr_hold", 8'd4, 1'b0, 0, 1'b1);
    send(8'h42);
    chk("ovr.valid_kept", frame_valid, 1);
    chk("ovr.len_kept", frame_len, 4);
    chk_pulses("ovr", 0, 0, 0, 1);
    readback("ovr_after");
    @(negedge clk);
    frame_ack = 1'b1;
    rx_data   = HDR;
    rx_ok     = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_ok     = 1'b0;
    chk("ovr_ack.valid", frame_valid, 0);
    chk_pulses("ovr_ack", 0, 0, 0, 1);

    send(HDR);
    send(8'h03);
    send(8'h11);
    chk("rst_mid.busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.outputs", {frame_valid, frame_len, busy, err_len, err_sum, err_timeout, overrun}, 0);
    chk_pulses("rst_mid", 0, 0, 0, 0);
    pl = '{8'h01, 8'h02};
    chk("rst_mid.sum_byte", calc_sum(8'd2), 8'h05);
    frame("after_rst", 8'd2, 1'b0, 0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 7) == 0)
        lb = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
      else
        lb = 8'($urandom_range(1, 16));
      pl.delete();
      if (lb >= 8'd1 && lb <= 8'd16)
        for (int i = 0; i < int'(lb); i++) pl.push_back(8'($urandom));
      frame($sformatf("rand%0d", f), lb, $urandom_range(0, 3) == 0, 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
